fp_store_data_queue: RTL and testbench

//  Drain end of the FPU store-data path: buffers FP store data produced by the FP execution unit
//  and hands it to the integer store-data / LSU port under ready/valid. Guarantees the producer

---
 rtl/fp_sdq_pkg.sv | 27 ++
 rtl/fp_sdq_ptr.sv | 39 +++
 rtl/fp_store_data_queue.sv | 131 +++++++++++++
 tb/tb_fp_store_data_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fp_sdq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sdq_pkg
//  Description : Shared types and helpers for the FP store-data queue.
//                sdq_entry_t is the payload stored per queue slot, sized by
//                the default widths below. clog2_min1 gives a pointer width
//                that never collapses to zero bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_sdq_pkg;

    localparam int SDQ_DEPTH  = 4;
    localparam int SDQ_DATA_W = 65;
    localparam int SDQ_ROB_W  = 7;

    typedef struct packed {
        logic [SDQ_DATA_W-1:0] data;
        logic [SDQ_ROB_W-1:0]  rob_idx;
    } sdq_entry_t;

    // Pointer width for an index range of 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_sdq_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fp_sdq_ptr
//  Description : Wrapping queue pointer. Counts 0..DEPTH-1 and returns to 0
//                by explicit compare, so DEPTH need not be a power of two.
//  Ports       : clock, reset (sync, active-low), i_inc (advance),
//                i_clr (return to 0, wins over i_inc), o_ptr (current index)
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_sdq_ptr
    import fp_sdq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = clog2_min1(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [PTR_W-1:0] o_ptr
);

    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] c_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clock) begin
        if (!reset || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + c_ONE;
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fp_store_data_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fp_store_data_queue
//  Description : FIFO for FP store data between the FPU writeback and the
//                LSU store-data arbiter. Advertises registered credits and
//                raises a sticky overflow flag on any enqueue attempt while
//                full. No enq->deq bypass: entries appear one cycle later.
//  Ports       : clock, reset (sync, active-low), i_flush (discard all)
//                enq side : i_enq_valid, o_enq_ready, i_enq_data, i_enq_rob_idx
//                deq side : o_deq_valid, i_deq_ready, o_deq_data, o_deq_rob_idx
//                status   : o_credits (DEPTH - count), o_overflow_err (sticky)
//  Config      : FP_SDQ_ASSERT_EN - compiles in simulation-only assertions
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_store_data_queue
    import fp_sdq_pkg::*;
#(
    parameter int DEPTH  = SDQ_DEPTH,
    parameter int DATA_W = SDQ_DATA_W,
    parameter int ROB_W  = SDQ_ROB_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_flush,
    input  logic                       i_enq_valid,
    output logic                       o_enq_ready,
    input  logic [DATA_W-1:0]          i_enq_data,
    input  logic [ROB_W-1:0]           i_enq_rob_idx,
    output logic                       o_deq_valid,
    input  logic                       i_deq_ready,
    output logic [DATA_W-1:0]          o_deq_data,
    output logic [ROB_W-1:0]           o_deq_rob_idx,
    output logic [$clog2(DEPTH+1)-1:0] o_credits,
    output logic                       o_overflow_err
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    // Local entry type follows the instance widths; matches sdq_entry_t at defaults.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob_idx;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_credits;
    logic             r_overflow;

    logic [PTR_W-1:0] w_head;
    logic [PTR_W-1:0] w_tail;
    logic             w_enq_ready;
    logic             w_deq_valid;
    logic             w_enq_fire;
    logic             w_deq_fire;

    // Ready/valid depend only on registered occupancy, never on i_deq_ready.
    assign w_enq_ready = (r_count != c_DEPTH);
    assign w_deq_valid = (r_count != '0);
    // Handshakes in a flush cycle are killed so no pointer or payload moves.
    assign w_enq_fire  = i_enq_valid & w_enq_ready & ~i_flush;
    assign w_deq_fire  = w_deq_valid & i_deq_ready & ~i_flush;

    fp_sdq_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_ptr (
        .clock (clock),
        .reset (reset),
        .i_inc (w_deq_fire),
        .i_clr (i_flush),
        .o_ptr (w_head)
    );

    fp_sdq_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_ptr (
        .clock (clock),
        .reset (reset),
        .i_inc (w_enq_fire),
        .i_clr (i_flush),
        .o_ptr (w_tail)
    );

    // Payload storage is not reset; occupancy alone qualifies it.
    always_ff @(posedge clock) begin
        if (w_enq_fire) begin
            r_mem[w_tail] <= '{data: i_enq_data, rob_idx: i_enq_rob_idx};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count    <= '0;
            r_credits  <= c_DEPTH;
            r_overflow <= 1'b0;
        end else begin
            if (i_enq_valid && !w_enq_ready) begin
                r_overflow <= 1'b1;
            end
            if (i_flush) begin
                r_count   <= '0;
                r_credits <= c_DEPTH;
            end else if (w_enq_fire && !w_deq_fire) begin
                r_count   <= r_count + c_ONE;
                r_credits <= r_credits - c_ONE;
            end else if (w_deq_fire && !w_enq_fire) begin
                r_count   <= r_count - c_ONE;
                r_credits <= r_credits + c_ONE;
            end
        end
    end

    assign o_enq_ready    = w_enq_ready;
    assign o_deq_valid    = w_deq_valid;
    assign o_deq_data     = r_mem[w_head].data;
    assign o_deq_rob_idx  = r_mem[w_head].rob_idx;
    assign o_credits      = r_credits;
    assign o_overflow_err = r_overflow;

`ifdef FP_SDQ_ASSERT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            a_no_overflow : assert (!(i_enq_valid && !w_enq_ready))
                else $error("fp_store_data_queue: enqueue while full");
            a_count_range : assert (int'(r_count) <= DEPTH);
            a_credit_sum  : assert (int'(r_credits) + int'(r_count) == DEPTH);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_store_data_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_store_data_queue
//  Description : Scoreboard bench for fp_store_data_queue. A DEPTH=4 instance
//                covers reset, fill/drain, overflow, flush collision and reset
//                mid-stream; a DEPTH=3 instance covers pointer wrap under
//                continuous streaming.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_store_data_queue;

    localparam int DW = 65;
    localparam int RW = 7;
    localparam int EW = DW + RW;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // DEPTH=4 instance
    logic          flush, enq_valid, enq_ready, deq_valid, deq_ready, ovf;
    logic [DW-1:0] enq_data, deq_data;
    logic [RW-1:0] enq_rob, deq_rob;
    logic [2:0]    credits;

    // DEPTH=3 instance
    logic          d3_flush, d3_enq_valid, d3_enq_ready, d3_deq_valid, d3_deq_ready, d3_ovf;
    logic [DW-1:0] d3_enq_data, d3_deq_data;
    logic [RW-1:0] d3_enq_rob, d3_deq_rob;
    logic [1:0]    d3_credits;

    fp_store_data_queue #(.DEPTH(4), .DATA_W(DW), .ROB_W(RW)) u_dut (
        .clock(clock), .reset(reset), .i_flush(flush),
        .i_enq_valid(enq_valid), .o_enq_ready(enq_ready),
        .i_enq_data(enq_data), .i_enq_rob_idx(enq_rob),
        .o_deq_valid(deq_valid), .i_deq_ready(deq_ready),
        .o_deq_data(deq_data), .o_deq_rob_idx(deq_rob),
        .o_credits(credits), .o_overflow_err(ovf)
    );

    fp_store_data_queue #(.DEPTH(3), .DATA_W(DW), .ROB_W(RW)) u_dut3 (
        .clock(clock), .reset(reset), .i_flush(d3_flush),
        .i_enq_valid(d3_enq_valid), .o_enq_ready(d3_enq_ready),
        .i_enq_data(d3_enq_data), .i_enq_rob_idx(d3_enq_rob),
        .o_deq_valid(d3_deq_valid), .i_deq_ready(d3_deq_ready),
        .o_deq_data(d3_deq_data), .o_deq_rob_idx(d3_deq_rob),
        .o_credits(d3_credits), .o_overflow_err(d3_ovf)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [EW-1:0] exp_q4 [$];
    logic [EW-1:0] exp_q3 [$];

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Monitors: compare every effective dequeue against the scoreboard head.
    always @(negedge clock) begin
        if (reset && !flush && deq_valid && deq_ready) begin
            if (exp_q4.size() == 0) begin
                n_total++;
                $display("FAIL d4_unexpected_deq: actual=%0h required=none", {deq_data, deq_rob});
            end else begin
                check("d4_deq_entry", {deq_data, deq_rob}, exp_q4.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (reset && !d3_flush && d3_deq_valid && d3_deq_ready) begin
            if (exp_q3.size() == 0) begin
                n_total++;
                $display("FAIL d3_unexpected_deq: actual=%0h required=none", {d3_deq_data, d3_deq_rob});
            end else begin
                check("d3_deq_entry", {d3_deq_data, d3_deq_rob}, exp_q3.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic enq4(input logic [DW-1:0] d, input logic [RW-1:0] r, input bit expect_out);
        enq_valid = 1'b1;
        enq_data  = d;
        enq_rob   = r;
        if (expect_out) exp_q4.push_back({d, r});
        tick();
        enq_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        flush = 0; enq_valid = 0; deq_ready = 0; enq_data = '0; enq_rob = '0;
        d3_flush = 0; d3_enq_valid = 0; d3_deq_ready = 0; d3_enq_data = '0; d3_enq_rob = '0;

        // Reset held low for two cycles
        reset = 1'b0;
        tick(); tick();
        check("rst_enq_ready", EW'(enq_ready), EW'(1));
        check("rst_deq_valid", EW'(deq_valid), EW'(0));
        check("rst_credits",   EW'(credits),   EW'(4));
        check("rst_overflow",  EW'(ovf),       EW'(0));
        check("rst_d3_credits", EW'(d3_credits), EW'(3));
        reset = 1'b1;
        tick();

        // Fill to full with deq_ready low
        for (int i = 0; i < 4; i++) enq4(DW'(32'hA + i), RW'(i + 1), 1'b1);
        check("full_enq_ready", EW'(enq_ready), EW'(0));
        check("full_credits",   EW'(credits),   EW'(0));
        check("full_deq_valid", EW'(deq_valid), EW'(1));

        // Overflow attempt: dropped, sticky flag
        enq4(DW'(32'hFF), RW'(99), 1'b0);
        check("ovf_set",  EW'(ovf), EW'(1));
        tick();
        check("ovf_hold", EW'(ovf), EW'(1));
        check("ovf_credits", EW'(credits), EW'(0));

        // Drain in order, one per cycle
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("drain_deq_valid", EW'(deq_valid), EW'(0));
        deq_ready = 1'b0;
        check("drain_credits",   EW'(credits),   EW'(4));
        check("drain_sb_empty",  EW'(exp_q4.size()), EW'(0));
        check("ovf_after_drain", EW'(ovf), EW'(1));

        // Flush collision at count=2
        enq4(DW'(32'h11), RW'(5), 1'b0);
        enq4(DW'(32'h22), RW'(6), 1'b0);
        check("pre_flush_credits", EW'(credits), EW'(2));
        flush = 1'b1; enq_valid = 1'b1; enq_data = DW'(32'h33); enq_rob = RW'(7); deq_ready = 1'b1;
        tick();
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        check("flush_deq_valid", EW'(deq_valid), EW'(0));
        check("flush_credits",   EW'(credits),   EW'(4));
        check("flush_enq_ready", EW'(enq_ready), EW'(1));
        check("flush_ovf_kept",  EW'(ovf),       EW'(1));
        enq4({1'b1, 64'hDEAD_BEEF_0000_0044}, RW'(44), 1'b1);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        check("post_flush_sb_empty", EW'(exp_q4.size()), EW'(0));
        check("post_flush_credits",  EW'(credits), EW'(4));

        // DEPTH=3 wrap: 10 entries with enq and deq every cycle
        d3_deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d3_enq_valid = 1'b1;
            d3_enq_data  = {1'b1, 64'h0123_4567_0000_0000 + 64'(i)};
            d3_enq_rob   = RW'(20 + i);
            exp_q3.push_back({d3_enq_data, d3_enq_rob});
            tick();
            check("d3_stream_credits", EW'(d3_credits), EW'(2));
        end
        d3_enq_valid = 1'b0;
        tick();
        d3_deq_ready = 1'b0;
        check("d3_sb_empty",  EW'(exp_q3.size()), EW'(0));
        check("d3_credits_end", EW'(d3_credits), EW'(3));
        check("d3_no_ovf",    EW'(d3_ovf), EW'(0));

        // Reset mid-stream with overflow set
        for (int i = 0; i < 4; i++) enq4(DW'(32'h50 + i), RW'(i), 1'b0);
        enq4(DW'(32'h99), RW'(9), 1'b0);
        check("mid_ovf_set", EW'(ovf), EW'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_ovf",       EW'(ovf),       EW'(0));
        check("mid_rst_credits",   EW'(credits),   EW'(4));
        check("mid_rst_deq_valid", EW'(deq_valid), EW'(0));
        check("mid_rst_enq_ready", EW'(enq_ready), EW'(1));

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
